// File: rtl/adpt_quan_iter.sv
// Iterative G.726 adaptive quantizer: converts difference signal D into codeword I,
// performing one normalize shift or one threshold compare per clock.
module adpt_quan_iter #(
  parameter int DW = 16,
  parameter int YW = 13,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strb,
  input  logic [1:0]    RATE,
  input  logic [DW-1:0] D,
  input  logic [YW-1:0] Y,
  output logic [IW-1:0] I,
  output logic          valid,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, NORM, LOG, CMP, OUT} state_t;

  state_t              state, state_nxt;
  logic                ds, ds_nxt;
  logic [DW-2:0]       dqm, dqm_nxt, dqm_in;
  logic [YW-3:0]       yq, yq_nxt;
  logic [1:0]          rate_q, rate_nxt;
  logic [3:0]          expo, expo_nxt;
  logic [11:0]         dln, dln_nxt;
  logic [3:0]          k, k_nxt;
  logic [IW-1:0]       i_nxt;
  logic                valid_nxt, busy_nxt, overrun_nxt;
  logic signed [11:0]  thr;
  logic [3:0]          last_k;
  logic [4:0]          top_code;
  logic [3:0]          mag;
  logic                cmp_done;
  logic [4:0]          code;

  // Normalized quantizer decision thresholds in the log2 domain (1/128 units), signed.
  function automatic logic signed [11:0] threshold(input logic [1:0] r, input logic [3:0] idx);
    logic signed [11:0] t;
    t = 12'sd2047;
    case (r)
      2'd0: begin
        case (idx)
          4'd0:    t = -12'sd122;
          4'd1:    t = -12'sd16;
          4'd2:    t = 12'sd68;
          4'd3:    t = 12'sd139;
          4'd4:    t = 12'sd198;
          4'd5:    t = 12'sd250;
          4'd6:    t = 12'sd298;
          4'd7:    t = 12'sd339;
          4'd8:    t = 12'sd378;
          4'd9:    t = 12'sd413;
          4'd10:   t = 12'sd445;
          4'd11:   t = 12'sd475;
          4'd12:   t = 12'sd502;
          4'd13:   t = 12'sd528;
          default: t = 12'sd553;
        endcase
      end
      2'd1: begin
        case (idx)
          4'd0:    t = -12'sd124;
          4'd1:    t = 12'sd80;
          4'd2:    t = 12'sd178;
          4'd3:    t = 12'sd246;
          4'd4:    t = 12'sd300;
          4'd5:    t = 12'sd349;
          default: t = 12'sd400;
        endcase
      end
      2'd2: begin
        case (idx)
          4'd0:    t = 12'sd8;
          4'd1:    t = 12'sd218;
          default: t = 12'sd331;
        endcase
      end
      default: t = 12'sd261;
    endcase
    return t;
  endfunction

  assign thr = threshold(rate_q, k);

  always_comb begin
    last_k   = 4'd0;
    top_code = 5'd3;
    case (rate_q)
      2'd0:    begin last_k = 4'd14; top_code = 5'd31; end
      2'd1:    begin last_k = 4'd6;  top_code = 5'd15; end
      2'd2:    begin last_k = 4'd2;  top_code = 5'd7;  end
      default: begin last_k = 4'd0;  top_code = 5'd3;  end
    endcase
  end

  // |D| in 15 bits; the most negative input has no positive twin and saturates.
  always_comb begin
    dqm_in = D[DW-2:0];
    if (D[DW-1]) begin
      if (D[DW-2:0] == '0) dqm_in = '1;
      else                 dqm_in = (DW-1)'(-D);
    end
  end

  // DLN values at or above 2048 are negative log ratios, so the compare is signed.
  always_comb begin
    cmp_done = 1'b0;
    mag      = k;
    if ($signed(dln) < thr) begin
      cmp_done = 1'b1;
    end else if (k == last_k) begin
      cmp_done = 1'b1;
      mag      = k + 4'd1;
    end
  end

  always_comb begin
    code = top_code;
    if (mag != 4'd0) code = ds ? (top_code - {1'b0, mag}) : {1'b0, mag};
  end

  always_comb begin
    state_nxt   = state;
    ds_nxt      = ds;
    dqm_nxt     = dqm;
    yq_nxt      = yq;
    rate_nxt    = rate_q;
    expo_nxt    = expo;
    dln_nxt     = dln;
    k_nxt       = k;
    i_nxt       = I;
    valid_nxt   = 1'b0;
    busy_nxt    = busy;
    overrun_nxt = overrun | (strb & (state != IDLE));
    case (state)
      IDLE: begin
        if (strb) begin
          ds_nxt    = D[DW-1];
          dqm_nxt   = dqm_in;
          yq_nxt    = (YW-2)'(Y >> 2);
          rate_nxt  = RATE;
          expo_nxt  = 4'd14;
          busy_nxt  = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (dqm[DW-2] || (expo == 4'd0)) begin
          state_nxt = LOG;
        end else begin
          dqm_nxt  = {dqm[DW-3:0], 1'b0};
          expo_nxt = expo - 4'd1;
        end
      end
      LOG: begin
        dln_nxt   = {1'b0, expo, dqm[13:7]} - {1'b0, yq};
        k_nxt     = 4'd0;
        state_nxt = CMP;
      end
      CMP: begin
        if (cmp_done) begin
          i_nxt     = IW'(code);
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = OUT;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ds      <= 1'b0;
      dqm     <= '0;
      yq      <= '0;
      rate_q  <= '0;
      expo    <= '0;
      dln     <= '0;
      k       <= '0;
      I       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      ds      <= ds_nxt;
      dqm     <= dqm_nxt;
      yq      <= yq_nxt;
      rate_q  <= rate_nxt;
      expo    <= expo_nxt;
      dln     <= dln_nxt;
      k       <= k_nxt;
      I       <= i_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_adpt_quan_iter.sv
// Directed bench for adpt_quan_iter: hand-computed codewords and latencies per rate,
// overrun, mid-conversion reset and back-to-back samples.
module tb_adpt_quan_iter;

  logic        test_clk = 1'b0;
  logic        reset;
  logic        strb;
  logic [1:0]  RATE;
  logic [15:0] D;
  logic [12:0] Y;
  logic [4:0]  I;
  logic        valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  always #5 test_clk = ~test_clk;

  adpt_quan_iter dut (
    .clk(test_clk), .reset(reset), .strb(strb), .RATE(RATE), .D(D), .Y(Y),
    .I(I), .valid(valid), .busy(busy), .overrun(overrun)
  );

  typedef struct packed {
    logic [1:0]  r;
    logic [15:0] d;
    logic [12:0] y;
    logic [4:0]  code;
    logic [7:0]  lat;
  } vec_t;

  // Expected codes/latencies derived from DLN = log2|D| - Y/4 and the G.726 tables.
  vec_t vecs [35] = '{
    '{2'd1, 16'd2,      13'd544, 5'd1,  8'd17},
    '{2'd1, -16'sd2,    13'd544, 5'd14, 8'd17},
    '{2'd1, 16'd3,      13'd544, 5'd1,  8'd17},
    '{2'd1, 16'd4,      13'd544, 5'd2,  8'd17},
    '{2'd1, 16'd6,      13'd544, 5'd3,  8'd18},
    '{2'd1, 16'd8,      13'd544, 5'd4,  8'd18},
    '{2'd1, 16'd10,     13'd544, 5'd4,  8'd18},
    '{2'd1, 16'd16,     13'd544, 5'd6,  8'd19},
    '{2'd1, -16'sd16,   13'd544, 5'd9,  8'd19},
    '{2'd1, 16'd0,      13'd496, 5'd1,  8'd18},
    '{2'd1, 16'd0,      13'd500, 5'd15, 8'd17},
    '{2'd1, 16'd12,     13'd547, 5'd5,  8'd19},
    '{2'd0, 16'd1,      13'd544, 5'd31, 8'd17},
    '{2'd0, 16'd2,      13'd544, 5'd2,  8'd18},
    '{2'd0, 16'd4,      13'd544, 5'd3,  8'd18},
    '{2'd0, 16'd6,      13'd544, 5'd4,  8'd19},
    '{2'd0, 16'd8,      13'd544, 5'd5,  8'd19},
    '{2'd0, -16'sd12,   13'd544, 5'd24, 8'd21},
    '{2'd0, 16'd16,     13'd544, 5'd8,  8'd21},
    '{2'd0, 16'd100,    13'd544, 5'd15, 8'd25},
    '{2'd0, -16'sd100,  13'd544, 5'd16, 8'd25},
    '{2'd0, 16'h8000,   13'd544, 5'd16, 8'd17},
    '{2'd0, 16'd0,      13'd488, 5'd1,  8'd18},
    '{2'd0, 16'd0,      13'd492, 5'd31, 8'd17},
    '{2'd2, 16'd2,      13'd544, 5'd7,  8'd16},
    '{2'd2, -16'sd2,    13'd544, 5'd7,  8'd16},
    '{2'd2, 16'd3,      13'd544, 5'd1,  8'd17},
    '{2'd2, -16'sd3,    13'd544, 5'd6,  8'd17},
    '{2'd2, 16'd8,      13'd544, 5'd2,  8'd16},
    '{2'd2, 16'd16,     13'd544, 5'd3,  8'd15},
    '{2'd2, -16'sd16,   13'd544, 5'd4,  8'd15},
    '{2'd3, 16'd8,      13'd544, 5'd3,  8'd14},
    '{2'd3, 16'd10,     13'd544, 5'd1,  8'd14},
    '{2'd3, -16'sd10,   13'd544, 5'd2,  8'd14},
    '{2'd3, 16'h8000,   13'd544, 5'd2,  8'd3}
  };

  // Issues one strobe, scrambles inputs after capture, waits up to 40 edges for valid.
  task automatic run_conv(input logic [1:0] r, input logic [15:0] d, input logic [12:0] y,
                          output logic [4:0] i_obs, output int lat, output bit timed_out,
                          output logic busy_start, output logic busy_at_valid);
    @(posedge test_clk); #1;
    strb = 1'b1; RATE = r; D = d; Y = y;
    @(posedge test_clk); #1;
    strb = 1'b0; RATE = ~r; D = 16'h5A5A; Y = 13'h1FFF;
    busy_start    = busy;
    busy_at_valid = 1'bx;
    i_obs         = 'x;
    lat           = 0;
    timed_out     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge test_clk); #1;
      if (valid) begin
        i_obs = I; lat = c; timed_out = 1'b0; busy_at_valid = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; strb = 1'b0; RATE = 2'd0; D = '0; Y = '0;
    repeat (2) @(posedge test_clk);
    #1;
    total++; if (I !== 5'd0)       begin bad++; $display("[TB] FAIL reset_I got=%0d want=0", I); end
    total++; if (valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
    total++; if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [4:0] i_obs; int lat; bit to; logic bs, bv;
    run_conv(2'd1, 16'd12, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd5) begin bad++; $display("[TB] FAIL basic_d12 got=%0d want=5 timeout=%0d", i_obs, to); end
    total++; if (lat != 19)            begin bad++; $display("[TB] FAIL basic_d12_latency got=%0d want=19", lat); end
    total++; if (bs !== 1'b1)          begin bad++; $display("[TB] FAIL busy_after_strb got=%b want=1", bs); end
    total++; if (bv !== 1'b0)          begin bad++; $display("[TB] FAIL busy_at_valid got=%b want=0", bv); end
    @(posedge test_clk); #1;
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL valid_one_cycle got valid=%b busy=%b want 0 0", valid, busy);
    end
    total++; if (I !== 5'd5) begin bad++; $display("[TB] FAIL I_held got=%0d want=5", I); end
    run_conv(2'd1, 16'd100, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd7 || lat != 17) begin bad++; $display("[TB] FAIL basic_d100 got=%0d lat=%0d want=7 lat=17", i_obs, lat); end
    run_conv(2'd1, -16'sd100, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd8 || lat != 17) begin bad++; $display("[TB] FAIL basic_dm100 got=%0d lat=%0d want=8 lat=17", i_obs, lat); end
    run_conv(2'd1, 16'd1, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd15 || lat != 17) begin bad++; $display("[TB] FAIL basic_d1 got=%0d lat=%0d want=15 lat=17", i_obs, lat); end
    run_conv(2'd1, 16'd0, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd15 || lat != 17) begin bad++; $display("[TB] FAIL basic_d0 got=%0d lat=%0d want=15 lat=17", i_obs, lat); end
    run_conv(2'd1, 16'h8000, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd8 || lat != 9) begin bad++; $display("[TB] FAIL basic_dmin got=%0d lat=%0d want=8 lat=9", i_obs, lat); end
  endtask

  task automatic test_sweep();
    logic [4:0] i_obs; int lat; bit to; logic bs, bv;
    int lat_min = 1000;
    int lat_max = 0;
    for (int v = 0; v < 35; v++) begin
      run_conv(vecs[v].r, vecs[v].d, vecs[v].y, i_obs, lat, to, bs, bv);
      total++;
      if (to || i_obs !== vecs[v].code || lat != int'(vecs[v].lat)) begin
        bad++;
        $display("[TB] FAIL sweep_%0d rate=%0d D=%0d Y=%0d got=%0d lat=%0d want=%0d lat=%0d",
                 v, vecs[v].r, $signed(vecs[v].d), vecs[v].y, i_obs, lat, vecs[v].code, vecs[v].lat);
      end
      if (!to && lat < lat_min) lat_min = lat;
      if (!to && lat > lat_max) lat_max = lat;
    end
    $display("[TB] sweep latency min=%0d max=%0d", lat_min, lat_max);
  endtask

  task automatic test_overrun();
    bit got = 1'b0;
    int lat = 0;
    @(posedge test_clk); #1;
    strb = 1'b1; RATE = 2'd1; D = 16'd12; Y = 13'd544;
    @(posedge test_clk); #1;
    strb = 1'b0;
    repeat (2) @(posedge test_clk);
    #1;
    strb = 1'b1; D = 16'd100;
    @(posedge test_clk); #1;
    strb = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set got=%b want=1", overrun); end
    for (int c = 4; c <= 40; c++) begin
      @(posedge test_clk); #1;
      if (valid) begin got = 1'b1; lat = c; break; end
    end
    total++; if (!got || I !== 5'd5 || lat != 19) begin
      bad++; $display("[TB] FAIL overrun_first_result got=%0d lat=%0d want=5 lat=19", I, lat);
    end
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge test_clk); #1;
      if (valid || busy) got = 1'b1;
    end
    total++; if (got) begin bad++; $display("[TB] FAIL overrun_dropped got activity=1 want=0"); end
    reset = 1'b0; #2;
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear got=%b want=0", overrun); end
    @(posedge test_clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_valid_collision();
    logic [4:0] i_obs; int lat; bit to; logic bs, bv;
    bit got = 1'b0;
    run_conv(2'd1, 16'd100, 13'd544, i_obs, lat, to, bs, bv);
    strb = 1'b1; D = 16'd12;
    @(posedge test_clk); #1;
    strb = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL collision_overrun got=%b want=1", overrun); end
    for (int c = 0; c < 40; c++) begin
      @(posedge test_clk); #1;
      if (valid || busy) got = 1'b1;
    end
    total++; if (got || I !== 5'd7) begin bad++; $display("[TB] FAIL collision_dropped got I=%0d active=%0d want I=7 active=0", I, got); end
    reset = 1'b0;
    @(posedge test_clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic [4:0] i_obs; int lat; bit to; logic bs, bv;
    bit got = 1'b0;
    run_conv(2'd1, 16'd100, 13'd544, i_obs, lat, to, bs, bv);
    @(posedge test_clk); #1;
    strb = 1'b1; RATE = 2'd1; D = 16'd1; Y = 13'd544;
    @(posedge test_clk); #1;
    strb = 1'b0;
    repeat (4) @(posedge test_clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_before got=%b want=1", busy); end
    reset = 1'b0; #2;
    total++; if (busy !== 1'b0 || I !== 5'd0 || valid !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_state got busy=%b I=%0d valid=%b want 0 0 0", busy, I, valid);
    end
    @(posedge test_clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 35; c++) begin
      @(posedge test_clk); #1;
      if (valid) got = 1'b1;
    end
    total++; if (got) begin bad++; $display("[TB] FAIL abort_no_valid got valid=1 want=0"); end
    run_conv(2'd1, 16'd12, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd5 || lat != 19) begin
      bad++; $display("[TB] FAIL abort_recover got=%0d lat=%0d want=5 lat=19", i_obs, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] i_obs; int lat; bit to; logic bs, bv;
    run_conv(2'd0, -16'sd12, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd24) begin bad++; $display("[TB] FAIL b2b_first got=%0d want=24", i_obs); end
    run_conv(2'd3, 16'd10, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd1) begin bad++; $display("[TB] FAIL b2b_second got=%0d want=1", i_obs); end
    run_conv(2'd2, -16'sd3, 13'd544, i_obs, lat, to, bs, bv);
    total++; if (to || i_obs !== 5'd6) begin bad++; $display("[TB] FAIL b2b_third got=%0d want=6", i_obs); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun got=%b want=0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_overrun();
    test_valid_collision();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired bad=%0d", bad + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
